// File: rtl/cordic_vec_ctrl.sv
// cordic_vec_ctrl
//   Iterative vectoring-mode CORDIC sequencer with quadrant pre-reflection.
//   Takes one signed (x,y) sample at a time. Samples with x<0 are reflected
//   through the origin and gain pi in the angle. The block then runs N
//   shift-add micro-rotations and presents the magnitude (CORDIC gain still
//   applied) and the angle.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   x_in/y_in valid
//   in_ready   sample can be accepted (IDLE only)
//   x_in,y_in  signed B-bit sample
//   out_valid  mag_out/angle_out/reflected valid, held until out_ready
//   out_ready  consumer takes the result
//   mag_out    unsigned magnitude * K, B+2 bits
//   angle_out  signed angle, 2^(W-1) LSB = pi, wraps modulo 2^W
//   reflected  sample had x_in<0
//   busy       controller not in IDLE
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for a sample, in_ready=1
// ITER  | one micro-rotation per edge, i = 0..N-1
// DONE  | result presented with out_valid=1 until out_ready

module cordic_vec_ctrl #(
  parameter int B = 14,
  parameter int N = 12,
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [B-1:0] x_in,
  input  logic signed [B-1:0] y_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [B+1:0]        mag_out,
  output logic signed [W-1:0] angle_out,
  output logic                reflected,
  output logic                busy
);

  // Two guard bits: one for negating -2^(B-1), one for the CORDIC gain.
  localparam int XW = B + 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [W-1:0] Z_PI = {1'b1, {(W-1){1'b0}}};

  // pi in Q60 fixed point, used to scale atan() into angle LSBs.
  localparam logic [127:0] PI_Q60 = 128'h3243F6A8885A308D;

  // round(atan(2^-i) * 2^(W-1) / pi). For i>=1 the Taylor series of atan
  // converges quickly (x <= 1/2) and every term is a power of two divided by
  // an odd integer, so the whole table is integer-only at elaboration.
  function automatic logic [W-1:0] atan_lsb(input int i);
    logic [127:0] acc;
    logic [127:0] term;
    logic [127:0] scaled;
    int p;
    if (i == 0) begin
      atan_lsb = W'(128'd1 << (W - 3));
    end else begin
      acc = '0;
      for (int k = 0; k < 32; k++) begin
        p = i * (2 * k + 1);
        if (p <= 60) begin
          term = (128'd1 << (60 - p)) / 128'(2 * k + 1);
          if (k % 2 == 0) acc = acc + term;
          else            acc = acc - term;
        end
      end
      scaled   = (acc << (W - 1)) + (PI_Q60 >> 1);
      atan_lsb = W'(scaled / PI_Q60);
    end
  endfunction

  logic [W-1:0] atan_tab [N];

  for (genvar g = 0; g < N; g++) begin : g_atan
    localparam logic [W-1:0] ATAN_G = atan_lsb(g);
    assign atan_tab[g] = ATAN_G;
  end

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t               state;
  logic signed [XW-1:0] x;
  logic signed [XW-1:0] y;
  logic [W-1:0]         z;
  logic [CW-1:0]        iter;
  logic signed [XW-1:0] x_ext;
  logic signed [XW-1:0] y_ext;

  assign x_ext     = {{2{x_in[B-1]}}, x_in};
  assign y_ext     = {{2{y_in[B-1]}}, y_in};
  assign mag_out   = $unsigned(x);
  assign angle_out = z;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      reflected <= 1'b0;
      busy      <= 1'b0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      iter      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (x_ext[XW-1]) begin
              x         <= -x_ext;
              y         <= -y_ext;
              z         <= Z_PI;
              reflected <= 1'b1;
            end else begin
              x         <= x_ext;
              y         <= y_ext;
              z         <= '0;
              reflected <= 1'b0;
            end
            iter     <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ITER;
          end
        end

        ITER: begin
          // Drive y toward zero; the sign of y picks the rotation direction.
          if (!y[XW-1]) begin
            x <= x + (y >>> iter);
            y <= y - (x >>> iter);
            z <= z + atan_tab[iter];
          end else begin
            x <= x - (y >>> iter);
            y <= y + (x >>> iter);
            z <= z - atan_tab[iter];
          end
          if (iter == LAST) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            iter <= iter + CW'(1);
          end
        end

        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
